// File: rtl/apu_pkg.sv
// Shared APU definitions: register offsets and the length-counter load table.
package apu_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_SWEEP = 2'd1;
  localparam logic [1:0] REG_PLO   = 2'd2;
  localparam logic [1:0] REG_PHI   = 2'd3;

  function automatic logic [7:0] length_lookup(input logic [4:0] idx);
    logic [7:0] v;
    v = 8'd0;
    case (idx)
      5'd0:  v = 8'd10;
      5'd1:  v = 8'd254;
      5'd2:  v = 8'd20;
      5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;
      5'd5:  v = 8'd4;
      5'd6:  v = 8'd80;
      5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;
      5'd9:  v = 8'd8;
      5'd10: v = 8'd60;
      5'd11: v = 8'd10;
      5'd12: v = 8'd14;
      5'd13: v = 8'd12;
      5'd14: v = 8'd26;
      5'd15: v = 8'd14;
      5'd16: v = 8'd12;
      5'd17: v = 8'd16;
      5'd18: v = 8'd24;
      5'd19: v = 8'd18;
      5'd20: v = 8'd48;
      5'd21: v = 8'd20;
      5'd22: v = 8'd96;
      5'd23: v = 8'd22;
      5'd24: v = 8'd192;
      5'd25: v = 8'd24;
      5'd26: v = 8'd72;
      5'd27: v = 8'd26;
      5'd28: v = 8'd16;
      5'd29: v = 8'd28;
      5'd30: v = 8'd32;
      5'd31: v = 8'd30;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/length_counter.sv
// Channel length counter: disable clears, load beats half-frame decrement.
module length_counter
  import apu_pkg::*;
(
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iLoad,
  input  logic [7:0] iLoad_value,
  input  logic       iLength_clk,
  input  logic       iHalt,
  input  logic       iEnable,
  output logic [7:0] oCount,
  output logic       oActive
);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oCount <= 8'd0;
    end else if (!iEnable) begin
      oCount <= 8'd0;
    end else if (iLoad) begin
      oCount <= iLoad_value;
    end else if (iLength_clk && oCount != 8'd0 && !iHalt) begin
      oCount <= oCount - 8'd1;
    end
  end

  assign oActive = (oCount != 8'd0);

endmodule

// File: rtl/rectangle_register_interface.sv
// Rectangle channel CPU register block: decode, field regs, delayed strobes.
module rectangle_register_interface
  import apu_pkg::*;
#(
  parameter logic [4:0] ADDR_BASE = 5'h00
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iWr_en,
  input  logic [4:0]  iAddr,
  input  logic [7:0]  iData,
  input  logic        iLength_clk,
  input  logic        iChannel_enable,
  output logic [1:0]  oDuty,
  output logic        oLength_halt,
  output logic        oConst_volume,
  output logic [3:0]  oVolume,
  output logic        oSweep_enable,
  output logic [2:0]  oSweep_refresh_rate,
  output logic        oSweep_mode,
  output logic [2:0]  oSweep_shift,
  output logic        oSweep_reset,
  output logic [10:0] oPeriod,
  output logic        oPeriod_reset,
  output logic        oEnvelope_restart,
  output logic [7:0]  oLength_count,
  output logic        oLength_active
);

  logic hit;
  logic wrCtrl;
  logic wrSweep;
  logic wrPlo;
  logic wrPhi;
  logic sweepPend;
  logic periodPend;
  logic periodStrobe;

  assign hit     = iWr_en && (iAddr[4:2] == ADDR_BASE[4:2]);
  assign wrCtrl  = hit && (iAddr[1:0] == REG_CTRL);
  assign wrSweep = hit && (iAddr[1:0] == REG_SWEEP);
  assign wrPlo   = hit && (iAddr[1:0] == REG_PLO);
  assign wrPhi   = hit && (iAddr[1:0] == REG_PHI);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oDuty               <= 2'd0;
      oLength_halt        <= 1'b0;
      oConst_volume       <= 1'b0;
      oVolume             <= 4'd0;
      oSweep_enable       <= 1'b0;
      oSweep_refresh_rate <= 3'd0;
      oSweep_mode         <= 1'b0;
      oSweep_shift        <= 3'd0;
      oPeriod             <= 11'd0;
    end else begin
      if (wrCtrl) begin
        oDuty         <= iData[7:6];
        oLength_halt  <= iData[5];
        oConst_volume <= iData[4];
        oVolume       <= iData[3:0];
      end
      if (wrSweep) begin
        oSweep_enable       <= iData[7];
        oSweep_refresh_rate <= iData[6:4];
        oSweep_mode         <= iData[3];
        oSweep_shift        <= iData[2:0];
      end
      if (wrPlo) begin
        oPeriod[7:0] <= iData;
      end
      if (wrPhi) begin
        oPeriod[10:8] <= iData[2:0];
      end
    end
  end

  // Strobes lag the field update by a cycle so downstream loads see stable data
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      sweepPend    <= 1'b0;
      periodPend   <= 1'b0;
      oSweep_reset <= 1'b0;
      periodStrobe <= 1'b0;
    end else begin
      sweepPend    <= wrSweep;
      periodPend   <= wrPhi;
      oSweep_reset <= sweepPend;
      periodStrobe <= periodPend;
    end
  end

  assign oPeriod_reset     = periodStrobe;
  assign oEnvelope_restart = periodStrobe;

  length_counter uLength (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .iLoad       (wrPhi),
    .iLoad_value (length_lookup(iData[7:3])),
    .iLength_clk (iLength_clk),
    .iHalt       (oLength_halt),
    .iEnable     (iChannel_enable),
    .oCount      (oLength_count),
    .oActive     (oLength_active)
  );

endmodule

// File: tb/tb_rectangle_register_interface.sv
// Randomised self-checking bench for the rectangle register interface.
module tb_rectangle_register_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [7:0]  data = 8'd0;
  logic        lclk = 1'b0;
  logic        en = 1'b1;

  logic [1:0]  duty;
  logic        halt;
  logic        cv;
  logic [3:0]  vol;
  logic        se;
  logic [2:0]  rr;
  logic        mode;
  logic [2:0]  shift;
  logic        sr;
  logic [10:0] period;
  logic        pr;
  logic        er;
  logic [7:0]  count;
  logic        active;

  rectangle_register_interface #(.ADDR_BASE(5'h04)) dut (
    .iClk                (clk),
    .iReset_n            (rst_n),
    .iWr_en              (wr),
    .iAddr               (addr),
    .iData               (data),
    .iLength_clk         (lclk),
    .iChannel_enable     (en),
    .oDuty               (duty),
    .oLength_halt        (halt),
    .oConst_volume       (cv),
    .oVolume             (vol),
    .oSweep_enable       (se),
    .oSweep_refresh_rate (rr),
    .oSweep_mode         (mode),
    .oSweep_shift        (shift),
    .oSweep_reset        (sr),
    .oPeriod             (period),
    .oPeriod_reset       (pr),
    .oEnvelope_restart   (er),
    .oLength_count       (count),
    .oLength_active      (active)
  );

  always #5 clk = ~clk;

  logic [38:0] dutVec;
  assign dutVec = {duty, halt, cv, vol, se, rr, mode, shift, sr,
                   period, pr, er, count, active};

  int n_checks = 0;
  int n_fail = 0;

  int tbl [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12,
                   26, 14, 12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72,
                   26, 16, 28, 32, 30};

  // Reference model state
  logic [1:0]  mDuty;
  logic        mHalt;
  logic        mCv;
  logic [3:0]  mVol;
  logic        mSe;
  logic [2:0]  mRr;
  logic        mMode;
  logic [2:0]  mShift;
  logic [10:0] mPeriod;
  int          mCount;
  logic        mSr, mPr, mSrArm, mPrArm;

  task automatic model_reset();
    mDuty = 0; mHalt = 0; mCv = 0; mVol = 0;
    mSe = 0; mRr = 0; mMode = 0; mShift = 0;
    mPeriod = 0; mCount = 0;
    mSr = 0; mPr = 0; mSrArm = 0; mPrArm = 0;
  endtask

  function automatic logic [38:0] model_vec();
    logic [7:0] c;
    c = 8'(mCount);
    return {mDuty, mHalt, mCv, mVol, mSe, mRr, mMode, mShift, mSr,
            mPeriod, mPr, mPr, c, (mCount != 0)};
  endfunction

  // One clock: drive at negedge, apply edge to the model, settle 1ns after.
  task automatic tick(input logic w, input logic [4:0] a,
                      input logic [7:0] d, input logic lc, input logic e);
    logic h;
    int   nc;
    @(negedge clk);
    wr = w; addr = a; data = d; lclk = lc; en = e;
    @(posedge clk);
    h  = w && (a[4:2] == 3'b001);
    nc = mCount;
    if (!e) nc = 0;
    else if (h && a[1:0] == 2'd3) nc = tbl[d[7:3]];
    else if (lc && mCount > 0 && !mHalt) nc = mCount - 1;
    mSr = mSrArm;
    mPr = mPrArm;
    mSrArm = h && a[1:0] == 2'd1;
    mPrArm = h && a[1:0] == 2'd3;
    if (h) begin
      case (a[1:0])
        2'd0: begin
          mDuty = d[7:6]; mHalt = d[5]; mCv = d[4]; mVol = d[3:0];
        end
        2'd1: begin
          mSe = d[7]; mRr = d[6:4]; mMode = d[3]; mShift = d[2:0];
        end
        2'd2: mPeriod = {mPeriod[10:8], d};
        default: mPeriod = {d[2:0], mPeriod[7:0]};
      endcase
    end
    mCount = nc;
    #1;
  endtask

  task automatic idle(input logic e);
    tick(1'b0, 5'd0, 8'd0, 1'b0, e);
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #12;
    n_checks++;
    if (dutVec !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", dutVec);
    end
    @(negedge clk);
    rst_n = 1;
    idle(1'b1);
    n_checks++;
    if (dutVec !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", dutVec, model_vec());
    end
  endtask

  task automatic test_ctrl();
    tick(1'b1, 5'h04, 8'hBF, 1'b0, 1'b1);
    n_checks++;
    if ({duty, halt, cv, vol} !== {2'd2, 1'b1, 1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL ctrl_fields: got %h want %h",
               {duty, halt, cv, vol}, {2'd2, 1'b1, 1'b1, 4'd15});
    end
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      n_checks++;
      if ({sr, pr, er} !== 3'b000) begin
        n_fail++;
        $display("FAIL ctrl_no_strobe: got %b want 000", {sr, pr, er});
      end
    end
  endtask

  task automatic test_sweep();
    tick(1'b1, 5'h05, 8'hA5, 1'b0, 1'b1);
    n_checks++;
    if ({se, rr, mode, shift} !== {1'b1, 3'd2, 1'b0, 3'd5} || sr !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_fields: got %h sr=%b want %h sr=0",
               {se, rr, mode, shift}, sr, {1'b1, 3'd2, 1'b0, 3'd5});
    end
    idle(1'b1);
    n_checks++;
    if (sr !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_pulse_hi: got %b want 1", sr);
    end
    idle(1'b1);
    n_checks++;
    if (sr !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_pulse_lo: got %b want 0", sr);
    end
    tick(1'b1, 5'h01, 8'h00, 1'b0, 1'b1);
    idle(1'b1);
    n_checks++;
    if ({se, rr, mode, shift} !== {1'b1, 3'd2, 1'b0, 3'd5} || sr !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_miss: got %h sr=%b want %h sr=0",
               {se, rr, mode, shift}, sr, {1'b1, 3'd2, 1'b0, 3'd5});
    end
  endtask

  task automatic test_period();
    tick(1'b1, 5'h06, 8'h34, 1'b0, 1'b1);
    tick(1'b1, 5'h07, 8'h0A, 1'b0, 1'b1);
    n_checks++;
    if (period !== 11'h234 || count !== 8'd254 || {pr, er} !== 2'b00) begin
      n_fail++;
      $display("FAIL period_load: got %h cnt=%0d st=%b want 234 cnt=254 st=00",
               period, count, {pr, er});
    end
    idle(1'b1);
    n_checks++;
    if ({pr, er} !== 2'b11) begin
      n_fail++;
      $display("FAIL period_pulse_hi: got %b want 11", {pr, er});
    end
    idle(1'b1);
    n_checks++;
    if ({pr, er} !== 2'b00) begin
      n_fail++;
      $display("FAIL period_pulse_lo: got %b want 00", {pr, er});
    end
  endtask

  task automatic test_length();
    tick(1'b1, 5'h04, 8'h00, 1'b0, 1'b1);
    tick(1'b1, 5'h07, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, 5'd0, 8'd0, 1'b1, 1'b1);
      n_checks++;
      if (count !== 8'(mCount) || active !== (mCount != 0)) begin
        n_fail++;
        $display("FAIL length_dec%0d: got %0d/%b want %0d/%b",
                 i, count, active, mCount, mCount != 0);
      end
    end
    n_checks++;
    if (count !== 8'd0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL length_floor: got %0d/%b want 0/0", count, active);
    end
    tick(1'b1, 5'h04, 8'h20, 1'b0, 1'b1);
    tick(1'b1, 5'h07, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 5'd0, 8'd0, 1'b1, 1'b1);
    n_checks++;
    if (count !== 8'd10) begin
      n_fail++;
      $display("FAIL length_halt: got %0d want 10", count);
    end
  endtask

  task automatic test_coincident();
    tick(1'b1, 5'h04, 8'h00, 1'b0, 1'b1);
    tick(1'b1, 5'h07, 8'h20, 1'b1, 1'b1);
    n_checks++;
    if (count !== 8'd40) begin
      n_fail++;
      $display("FAIL load_beats_clk: got %0d want 40", count);
    end
    idle(1'b0);
    n_checks++;
    if (count !== 8'd0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_clear: got %0d/%b want 0/0", count, active);
    end
    tick(1'b1, 5'h07, 8'h08, 1'b0, 1'b0);
    n_checks++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL disabled_load: got %0d want 0", count);
    end
    idle(1'b1);
    n_checks++;
    if ({pr, er} !== 2'b11) begin
      n_fail++;
      $display("FAIL disabled_strobe: got %b want 11", {pr, er});
    end
    idle(1'b1);
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 5'h07, 8'h08, 1'b0, 1'b1);
    tick(1'b1, 5'h07, 8'h10, 1'b0, 1'b1);
    n_checks++;
    if (count !== 8'd20 || pr !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d pr=%b want 20 pr=1", count, pr);
    end
    idle(1'b1);
    n_checks++;
    if (pr !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got pr=%b want 1", pr);
    end
    idle(1'b1);
    n_checks++;
    if (pr !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got pr=%b want 0", pr);
    end
  endtask

  task automatic test_reset_mid_pulse();
    tick(1'b1, 5'h07, 8'h08, 1'b0, 1'b1);
    tick(1'b1, 5'h07, 8'h08, 1'b0, 1'b1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (dutVec !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0", dutVec);
    end
    @(negedge clk);
    wr = 0;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      n_checks++;
      if ({sr, pr, er} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_no_pulse%0d: got %b want 000", i, {sr, pr, er});
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                      : 5'(4 + $urandom_range(0, 3));
      tick(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0));
      n_checks++;
      if (dutVec !== model_vec()) begin
        n_fail++;
        $display("FAIL random%0d: got %h want %h", i, dutVec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_sweep();
    test_period();
    test_length();
    test_coincident();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rectangle_register_interface.md
# rectangle_register_interface

CPU-side register interface for one NES APU rectangle channel. It decodes 8-bit CPU writes to the channel's four registers ($4000–$4003 or $4004–$4007) into the control fields, load strobes and length-counter state that the channel's sweep/frequency generator, envelope and mixer consume. It sits between the APU bus decoder and the rectangle channel datapath, and it is the writer for the sweep unit's period and sweep inputs.

## Interface
- ADDR_BASE, 5'h00, offset of this channel's register block within $4000–$401F; must be a multiple of 4 (5'h00 = pulse 1, 5'h04 = pulse 2).
- iClk  in  1  system clock.
- iReset_n  in  1  asynchronous, active-low reset.
- iWr_en  in  1  CPU write strobe; one write per high cycle.
- iAddr  in  5  low 5 bits of the CPU address.
- iData  in  8  CPU write data.
- iLength_clk  in  1  half-frame pulse from the frame sequencer, one cycle wide.
- iChannel_enable  in  1  this channel's $4015 enable bit.
- oDuty  out  2  duty select.
- oLength_halt  out  1  length-counter halt, also envelope loop.
- oConst_volume  out  1  constant-volume flag.
- oVolume  out  4  volume or envelope period.
- oSweep_enable  out  1  sweep enable.
- oSweep_refresh_rate  out  3  sweep divider period.
- oSweep_mode  out  1  0 = add, 1 = subtract.
- oSweep_shift  out  3  sweep shift count.
- oSweep_reset  out  1  one-cycle pulse after a write to reg 1.
- oPeriod  out  11  timer period.
- oPeriod_reset  out  1  one-cycle pulse after a write to reg 3.
- oEnvelope_restart  out  1  one-cycle pulse after a write to reg 3.
- oLength_count  out  8  current length counter.
- oLength_active  out  1  high when oLength_count != 0; the mixer silences the channel when this is low.

## Operation
- Address hit: iWr_en && iAddr[4:2] == ADDR_BASE[4:2]. The register offset is iAddr[1:0]. Writes with no hit are ignored.
- Reg 0: oDuty = D[7:6], oLength_halt = D[5], oConst_volume = D[4], oVolume = D[3:0].
- Reg 1: oSweep_enable = D[7], oSweep_refresh_rate = D[6:4], oSweep_mode = D[3], oSweep_shift = D[2:0]. The write also arms oSweep_reset.
- Reg 2: oPeriod[7:0] = D. No pulse is generated.
- Reg 3: oPeriod[10:8] = D[2:0]. The write also arms oPeriod_reset and oEnvelope_restart.
  - If iChannel_enable = 1, oLength_count = LENGTH_TABLE[D[7:3]].
  - If iChannel_enable = 0, the length counter is not loaded.
- Length counter, evaluated each cycle in priority order:
  1. iChannel_enable = 0 → the counter is cleared to 0.
  2. Reg 3 load → the counter takes the table value.
  3. iLength_clk && count != 0 && !oLength_halt → the counter decrements by 1.
  4. Otherwise the counter holds.
- Arithmetic: the decrement never wraps; at 0 the counter holds 0.
- The halt value used in step 3 is the registered oLength_halt. A reg 0 write in the same cycle takes effect from the next cycle.
- LENGTH_TABLE (index 0–31): 10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14, 12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30.

## Timing
- Reset (iReset_n low, asynchronous): every output is 0, including the counter and all pulses.
- Write sampled at edge N:
  - Field outputs and oLength_count update at edge N.
  - Strobes are high from edge N+1 to edge N+2.
  - This one-cycle delay guarantees that oPeriod and the sweep fields are stable before the downstream asynchronous load sees oPeriod_reset or oSweep_reset.
- Back-to-back reg 3 writes in consecutive cycles keep oPeriod_reset high continuously, and each load still applies.
- iLength_clk coincident with a reg 3 load: the load wins and there is no decrement that cycle.
- iChannel_enable falling while a reg 3 write is pending: the counter is 0 at the next edge, and the strobes still fire.
- Reset asserted mid-pulse: the pulse drops immediately, and no pulse follows after iReset_n rises.

## Structure
- Package apu_pkg:
  - register offset constants REG_CTRL = 0, REG_SWEEP = 1, REG_PLO = 2, REG_PHI = 3;
  - LENGTH_TABLE as a function length_lookup(5-bit) → 8-bit.
- Sub-module length_counter: load, load value, clock, halt and enable inputs; 8-bit count and active outputs. The triangle and noise channels reuse it.
- The top level holds the address decode, the field registers and the strobe delay flops.

## Test plan
- Reset, then write reg 0 = 8'hBF → oDuty = 2, oLength_halt = 1, oConst_volume = 1, oVolume = 15; no strobes fire.
- Write reg 1 = 8'hA5, with pulse 2 (ADDR_BASE = 5'h04, iAddr = 5'h05) → sweep fields 1/2/0/5 at edge N; oSweep_reset high for exactly cycle N+1; a write to iAddr 5'h01 is ignored.
- Write reg 2 = 8'h34, then reg 3 = 8'h0A with enable = 1 → oPeriod = 11'h234, oLength_count = 254 (index 1); oPeriod_reset and oEnvelope_restart each pulse once, one cycle after the write.
- Load count 10, halt = 0, apply 10 iLength_clk pulses → oLength_count reaches 0, oLength_active falls, and an 11th pulse leaves it at 0. With halt = 1, the count holds.
- Reg 3 write coincident with iLength_clk → the count equals the table value with no decrement. Drop iChannel_enable → the count is 0 next cycle, and a reg 3 write while disabled leaves it 0.
- Assert iReset_n low during an oPeriod_reset pulse → all outputs are 0 asynchronously, and no strobe fires after release.
